// File: rtl/pu_pkg.sv
// Shared types, default widths and the saturation helper for the requantising
// MAC array.
package pu_pkg;

   typedef enum logic [1:0] {IDLE, DRAIN, FLUSH} state_t;

   localparam int DATA_W_DEF  = 8;
   localparam int ACC_W_DEF   = 24;
   localparam int LANES_DEF   = 128;
   localparam int COEFF_W_DEF = 17;
   localparam int SHIFT_W_DEF = 6;

   // Clamp a signed value into a width-bit signed range; lo_zero raises the floor to 0.
   function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                              input int width,
                                              input logic lo_zero);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (width - 1)) - 64'sd1;
      lo = lo_zero ? 64'sd0 : -(64'sd1 <<< (width - 1));
      if (value > hi)
         sat = hi;
      else if (value < lo)
         sat = lo;
      else
         sat = value;
   endfunction

endpackage

// File: rtl/pu_mac_lane.sv
// One MAC lane: signed product of the broadcast activation and this lane's
// weight, added into a saturating accumulator. Clear wins over the old value.
module pu_mac_lane
   import pu_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     clear,
   input  logic                     acc_en,
   input  logic signed [DATA_W-1:0] din,
   input  logic signed [DATA_W-1:0] w,
   output logic signed [ACC_W-1:0]  acc
);

   logic signed [2*DATA_W-1:0] din_x;
   logic signed [2*DATA_W-1:0] w_x;
   logic signed [2*DATA_W-1:0] prod;
   logic signed [63:0]         base;
   logic signed [63:0]         sum;

   assign din_x = {{DATA_W{din[DATA_W-1]}}, din};
   assign w_x   = {{DATA_W{w[DATA_W-1]}}, w};
   assign prod  = din_x * w_x;

   always_comb begin
      base = clear ? 64'sd0 : {{(64-ACC_W){acc[ACC_W-1]}}, acc};
      sum  = base + {{(64-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i)
         acc <= '0;
      else if (acc_en)
         acc <= ACC_W'(sat(sum, ACC_W, 1'b0));
      else if (clear)
         acc <= '0;
   end

endmodule

// File: rtl/pu_requant_array.sv
// LANES-wide MAC array with a snapshot buffer that drains lane-serially through
// a multiply / round / saturate / ReLU requantiser onto a valid-ready stream.
//
//   state | meaning
//   IDLE  | waiting for drain_i; snapshot and requant settings load on it
//   DRAIN | issuing one snapshot lane into the pipeline per advancing cycle
//   FLUSH | all lanes issued; waiting for the last beat to be accepted
module pu_requant_array
   import pu_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int ACC_W   = ACC_W_DEF,
   parameter int LANES   = LANES_DEF,
   parameter int COEFF_W = COEFF_W_DEF,
   parameter int SHIFT_W = SHIFT_W_DEF,
   parameter int IDX_W   = $clog2(LANES)
) (
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      clear_i,
   input  logic                      acc_en_i,
   input  logic signed [DATA_W-1:0]  din_i,
   input  logic [LANES*DATA_W-1:0]   win_i,
   input  logic                      drain_i,
   input  logic [COEFF_W-1:0]        coeff_i,
   input  logic [SHIFT_W-1:0]        shift_i,
   input  logic                      relu_en_i,
   output logic                      busy_o,
   output logic                      m_valid_o,
   input  logic                      m_ready_i,
   output logic signed [DATA_W-1:0]  m_data_o,
   output logic                      m_last_o,
   output logic                      done_o
);

   localparam int P_W = ACC_W + COEFF_W + 1;
   localparam int R_W = P_W + 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   logic signed [ACC_W-1:0] acc  [LANES];
   logic signed [ACC_W-1:0] snap [LANES];

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      pu_mac_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
         .clk_i  (clk_i),
         .rstn_i (rstn_i),
         .clear  (clear_i),
         .acc_en (acc_en_i),
         .din    (din_i),
         .w      (win_i[k*DATA_W +: DATA_W]),
         .acc    (acc[k])
      );
   end

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [COEFF_W-1:0]   coeff_q;
   logic [SHIFT_W-1:0]   shift_q;
   logic                 relu_q;

   logic                 s1_valid, s1_last;
   logic signed [P_W-1:0] s1_p;
   logic                 s2_valid, s2_last;
   logic signed [R_W-1:0] s2_r;
   logic                 s3_valid, s3_last;
   logic signed [DATA_W-1:0] s3_d;

   logic                  adv;
   logic signed [ACC_W-1:0] snap_sel;
   logic signed [P_W-1:0] snap_x;
   logic signed [P_W-1:0] coeff_x;
   logic signed [P_W-1:0] prod;
   logic signed [R_W-1:0] p_x;
   logic signed [R_W-1:0] rnd;
   logic signed [R_W-1:0] r_full;
   logic signed [63:0]    r_ext;

   assign adv      = !m_valid_o || m_ready_i;
   assign snap_sel = snap[idx];
   assign snap_x   = {{(P_W-ACC_W){snap_sel[ACC_W-1]}}, snap_sel};
   assign coeff_x  = {{(P_W-COEFF_W){1'b0}}, coeff_q};
   assign prod     = snap_x * coeff_x;

   // Shifts at or beyond the product width always round to zero, so they are
   // short-circuited to keep the rounding constant inside R_W bits.
   always_comb begin
      p_x    = {s1_p[P_W-1], s1_p};
      rnd    = '0;
      r_full = '0;
      if (int'(shift_q) < P_W) begin
         if (shift_q != '0)
            rnd = R_W'(1) <<< (shift_q - SHIFT_W'(1));
         r_full = (p_x + rnd) >>> shift_q;
      end
   end

   assign r_ext = {{(64-R_W){s2_r[R_W-1]}}, s2_r};

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         for (int k = 0; k < LANES; k++)
            snap[k] <= '0;
      end else if (state == IDLE && drain_i) begin
         snap <= acc;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         idx       <= '0;
         coeff_q   <= '0;
         shift_q   <= '0;
         relu_q    <= 1'b0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         s1_valid  <= 1'b0;
         s1_last   <= 1'b0;
         s1_p      <= '0;
         s2_valid  <= 1'b0;
         s2_last   <= 1'b0;
         s2_r      <= '0;
         s3_valid  <= 1'b0;
         s3_last   <= 1'b0;
         s3_d      <= '0;
         m_valid_o <= 1'b0;
         m_last_o  <= 1'b0;
         m_data_o  <= '0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: begin
               if (drain_i) begin
                  state   <= DRAIN;
                  idx     <= '0;
                  coeff_q <= coeff_i;
                  shift_q <= shift_i;
                  relu_q  <= relu_en_i;
                  busy_o  <= 1'b1;
               end
            end
            DRAIN: begin
               if (adv) begin
                  if (idx == LAST_IDX)
                     state <= FLUSH;
                  else
                     idx <= idx + IDX_W'(1);
               end
            end
            FLUSH: begin
               if (m_valid_o && m_ready_i && m_last_o) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  done_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase

         if (adv) begin
            s1_valid  <= (state == DRAIN);
            s1_last   <= (idx == LAST_IDX);
            s1_p      <= prod;
            s2_valid  <= s1_valid;
            s2_last   <= s1_last;
            s2_r      <= r_full;
            s3_valid  <= s2_valid;
            s3_last   <= s2_last;
            s3_d      <= DATA_W'(sat(r_ext, DATA_W, relu_q));
            m_valid_o <= s3_valid;
            m_last_o  <= s3_last;
            m_data_o  <= s3_d;
         end
      end
   end

endmodule

// File: tb/tb_pu_requant_array.sv
// Self-checking bench for pu_requant_array with four lanes: table vectors,
// hand-built multi-cycle sequences and random traffic against an arithmetic model.
module tb_pu_requant_array;

   localparam int DW = 8;
   localparam int AW = 24;
   localparam int L  = 4;
   localparam int CW = 17;
   localparam int SW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rstn;
   logic                 clear;
   logic                 acc_en;
   logic signed [DW-1:0] din;
   logic [L*DW-1:0]      win;
   logic                 drain;
   logic [CW-1:0]        coeff;
   logic [SW-1:0]        shift;
   logic                 relu;
   logic                 busy;
   logic                 m_valid;
   logic                 m_ready;
   logic signed [DW-1:0] m_data;
   logic                 m_last;
   logic                 done;

   logic signed [DW-1:0] wv [L];

   always_comb begin
      win = '0;
      for (int k = 0; k < L; k++)
         win[k*DW +: DW] = wv[k];
   end

   pu_requant_array #(
      .DATA_W(DW), .ACC_W(AW), .LANES(L), .COEFF_W(CW), .SHIFT_W(SW)
   ) dut (
      .clk_i     (clk),
      .rstn_i    (rstn),
      .clear_i   (clear),
      .acc_en_i  (acc_en),
      .din_i     (din),
      .win_i     (win),
      .drain_i   (drain),
      .coeff_i   (coeff),
      .shift_i   (shift),
      .relu_en_i (relu),
      .busy_o    (busy),
      .m_valid_o (m_valid),
      .m_ready_i (m_ready),
      .m_data_o  (m_data),
      .m_last_o  (m_last),
      .done_o    (done)
   );

   int checks = 0;
   int failures = 0;
   longint macc [L];

   typedef struct {
      longint acc [L];
      int     coeff;
      int     shift;
      bit     relu;
      longint exp [L];
   } vec_t;

   vec_t tv [6];

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic longint satm(input longint v, input int w, input bit lz);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = lz ? 0 : -(longint'(1) <<< (w - 1));
      return (v > hi) ? hi : (v < lo) ? lo : v;
   endfunction

   // Requantisation straight from the arithmetic definition.
   function automatic longint rq(input longint a, input longint c, input int s, input bit r);
      longint p;
      p = a * c;
      if (s > 0)
         p = p + (longint'(1) <<< (s - 1));
      p = p >>> s;
      return satm(p, DW, r);
   endfunction

   task automatic step();
      for (int k = 0; k < L; k++) begin
         if (acc_en)
            macc[k] = satm((clear ? 0 : macc[k]) + longint'(din) * longint'(wv[k]), AW, 1'b0);
         else if (clear)
            macc[k] = 0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load_acc(input longint tgt [L]);
      longint rem [L];
      longint chunk;
      bit     first;
      bit     pending;
      int     guard;
      rem = tgt;
      first = 1'b1;
      pending = 1'b1;
      guard = 0;
      while ((first || pending) && guard < 40) begin
         clear  = first;
         acc_en = 1'b1;
         din    = 8'sd1;
         pending = 1'b0;
         for (int k = 0; k < L; k++) begin
            chunk = (rem[k] > 127) ? 127 : (rem[k] < -128) ? -128 : rem[k];
            wv[k] = DW'(chunk);
            rem[k] = rem[k] - chunk;
            if (rem[k] != 0)
               pending = 1'b1;
         end
         step();
         first = 1'b0;
         guard++;
      end
      clear  = 1'b0;
      acc_en = 1'b0;
   endtask

   task automatic do_drain(input int c, input int s, input bit r, input longint exp [L],
                           input int stall_beat, input int stall_len, input bit overlap,
                           input string tag);
      int nb, first, stall, done_at;
      nb = 0; first = -1; stall = 0; done_at = -1;
      coeff = CW'(c); shift = SW'(s); relu = r; drain = 1'b1; m_ready = 1'b1;
      step();
      drain = 1'b0;
      for (int t = 0; t < 200 && done_at < 0; t++) begin
         clear  = overlap && (t == 1);
         acc_en = overlap && (t == 2);
         drain  = overlap && (t == 2);
         if (overlap && t == 2) begin
            din = DW'($urandom);
            for (int k = 0; k < L; k++)
               wv[k] = DW'($urandom);
         end
         m_ready = !(nb == stall_beat && stall < stall_len);
         if (m_valid) begin
            if (first < 0)
               first = t;
            if (nb < L) begin
               chk($sformatf("%s data lane%0d", tag, nb), longint'(m_data), exp[nb]);
               chk($sformatf("%s last lane%0d", tag, nb), longint'(m_last), longint'(nb == L - 1));
            end else begin
               chk($sformatf("%s extra beat", tag), nb, L - 1);
            end
            if (m_ready) nb++;
            else stall++;
         end
         if (done) begin
            done_at = t;
            chk({tag, " busy at done"}, longint'(busy), 0);
         end else begin
            step();
         end
      end
      clear = 1'b0; acc_en = 1'b0; drain = 1'b0; m_ready = 1'b1;
      chk({tag, " first valid cycle"}, first, 4);
      chk({tag, " done cycle"}, done_at, 4 + L + stall_len);
      chk({tag, " beat count"}, nb, L);
      step();
      chk({tag, " done one cycle"}, longint'(done), 0);
      chk({tag, " idle valid"}, longint'(m_valid), 0);
   endtask

   initial begin
      longint e [L];
      int c, s, sb, sl, n;
      bit r;

      tv[0] = '{'{3, -3, 5, 0},          1, 1, 1'b0, '{2, -1, 3, 0}};
      tv[1] = '{'{5, -5, 1, -1},         1, 0, 1'b0, '{5, -5, 1, -1}};
      tv[2] = '{'{1000, -1000, 127, -128}, 1, 0, 1'b0, '{127, -128, 127, -128}};
      tv[3] = '{'{-1000, 50, 0, -1},     1, 0, 1'b1, '{0, 50, 0, 0}};
      tv[4] = '{'{-1, -2, 1, 2},         1, 1, 1'b0, '{0, -1, 1, 1}};
      tv[5] = '{'{100, -100, 7, -7},     3, 2, 1'b0, '{75, -75, 5, -5}};

      rstn = 1'b0; clear = 1'b0; acc_en = 1'b0; din = '0; drain = 1'b0;
      coeff = '0; shift = '0; relu = 1'b0; m_ready = 1'b1;
      for (int k = 0; k < L; k++) begin
         wv[k] = '0;
         macc[k] = 0;
      end

      #12;
      chk("reset m_valid", longint'(m_valid), 0);
      chk("reset busy", longint'(busy), 0);
      chk("reset done", longint'(done), 0);
      chk("reset m_last", longint'(m_last), 0);
      chk("reset m_data", longint'(m_data), 0);
      @(posedge clk);
      #1;
      rstn = 1'b1;

      // Basic MAC: w = k+1, din = 2, three accumulate cycles.
      for (int k = 0; k < L; k++)
         wv[k] = DW'(k + 1);
      din = 8'sd2;
      acc_en = 1'b1;
      repeat (3) step();
      acc_en = 1'b0;
      e = '{6, 12, 18, 24};
      do_drain(65536, 16, 1'b0, e, -1, 0, 1'b0, "basic");

      for (int i = 0; i < 6; i++) begin
         load_acc(tv[i].acc);
         do_drain(tv[i].coeff, tv[i].shift, tv[i].relu, tv[i].exp, -1, 0, 1'b0,
                  $sformatf("vec%0d", i));
      end

      // Backpressure on beat 1 for three cycles.
      e = '{6, 12, 18, 24};
      load_acc(e);
      do_drain(65536, 16, 1'b0, e, 1, 3, 1'b0, "bp");

      // Clear and accumulate while draining; stray drain_i while busy.
      for (int k = 0; k < L; k++)
         e[k] = rq(macc[k], 1, 0, 1'b0);
      do_drain(1, 0, 1'b0, e, -1, 0, 1'b1, "ovl");
      for (int k = 0; k < L; k++)
         e[k] = rq(macc[k], 1, 0, 1'b0);
      do_drain(1, 0, 1'b0, e, -1, 0, 1'b0, "ovl_next");

      // Drive the accumulators well past both rails.
      din = 8'sd127;
      wv[0] = 8'sd127; wv[1] = -8'sd127; wv[2] = 8'sd0; wv[3] = 8'sd1;
      clear = 1'b1; acc_en = 1'b1;
      step();
      clear = 1'b0;
      repeat (599) step();
      acc_en = 1'b0;
      e = '{64, -64, 0, 1};
      do_drain(1, 17, 1'b0, e, -1, 0, 1'b0, "accsat");

      for (int it = 0; it < 5; it++) begin
         n = $urandom_range(1, 8);
         for (int j = 0; j < n; j++) begin
            clear  = ($urandom % 6) == 0;
            acc_en = ($urandom % 4) != 0;
            din    = DW'($urandom);
            for (int k = 0; k < L; k++)
               wv[k] = DW'($urandom);
            step();
         end
         clear = 1'b0; acc_en = 1'b0;
         c  = $urandom_range(0, 131071);
         s  = $urandom_range(0, 30);
         r  = $urandom_range(0, 1);
         sb = $urandom_range(0, L - 1);
         sl = $urandom_range(0, 3);
         for (int k = 0; k < L; k++)
            e[k] = rq(macc[k], c, s, r);
         do_drain(c, s, r, e, sb, sl, 1'b0, $sformatf("rnd%0d", it));
      end

      // Asynchronous reset in the middle of a stream.
      e = '{40, -40, 7, 9};
      load_acc(e);
      coeff = CW'(1); shift = '0; relu = 1'b0; drain = 1'b1; m_ready = 1'b1;
      step();
      drain = 1'b0;
      repeat (5) step();
      chk("pre-reset streaming", longint'(m_valid), 1);
      #2;
      rstn = 1'b0;
      #1;
      chk("async reset m_valid", longint'(m_valid), 0);
      chk("async reset busy", longint'(busy), 0);
      chk("async reset done", longint'(done), 0);
      for (int k = 0; k < L; k++)
         macc[k] = 0;
      @(posedge clk);
      #1;
      rstn = 1'b1;
      step();
      chk("post-reset no done", longint'(done), 0);
      e = '{0, 0, 0, 0};
      do_drain(12345, 3, 1'b0, e, -1, 0, 1'b0, "post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
